// File: rtl/voltage_text_buffer_pkg.sv
// Shared constants, state encoding and text/BCD helpers for the voltage text buffer.
package voltage_text_buffer_pkg;

  localparam int unsigned ROWS        = 13;
  localparam int unsigned COLS        = 12;
  localparam int unsigned XY_W        = 8;
  localparam int unsigned LINE_W      = 4;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned CH_W        = 4;
  localparam int unsigned MV_W        = 12;
  localparam int unsigned BCD_W       = 16;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned CODE_W      = 7;
  localparam int unsigned CONV_CYCLES = 12;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_V     = 8'h56;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CONVERT = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [MV_W-1:0] mv;
  } upd_t;

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Character at a column of "CHnn: d.dddV"; label is the 1-based row number.
  function automatic logic [7:0] text_char(input logic [7:0]       col,
                                           input logic [7:0]       label,
                                           input logic [BCD_W-1:0] bcd);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = label / 8'd10;
    units = label % 8'd10;
    case (col)
      8'd0:    return ASCII_C;
      8'd1:    return ASCII_H;
      8'd2:    return ASCII_0 + tens;
      8'd3:    return ASCII_0 + units;
      8'd4:    return ASCII_COLON;
      8'd5:    return ASCII_SPACE;
      8'd6:    return ASCII_0 + 8'(bcd[15:12]);
      8'd7:    return ASCII_DOT;
      8'd8:    return ASCII_0 + 8'(bcd[11:8]);
      8'd9:    return ASCII_0 + 8'(bcd[7:4]);
      8'd10:   return ASCII_0 + 8'(bcd[3:0]);
      8'd11:   return ASCII_V;
      default: return ASCII_SPACE;
    endcase
  endfunction

endpackage

// File: rtl/voltage_text_buffer_font_rom.sv
// 8x16 glyph ROM, 128 characters, registered read. Only glyphs the buffer can emit are populated.
module font_rom
  import voltage_text_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] i_char,
  input  logic [LINE_W-1:0] i_line,
  output logic [PIX_W-1:0]  o_pixel
);

  logic [127:0]     w_glyph;
  logic [6:0]       w_sel;
  logic [PIX_W-1:0] r_pixel;

  // Glyph line 0 sits in the top byte of each 128-bit constant.
  always_comb begin
    w_glyph = '0;
    case (i_char)
      7'h30:   w_glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      7'h31:   w_glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      7'h32:   w_glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      7'h33:   w_glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      7'h34:   w_glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      7'h35:   w_glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      7'h36:   w_glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      7'h37:   w_glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      7'h38:   w_glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      7'h39:   w_glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      7'h2E:   w_glyph = 128'h0000_0000_0000_0000_0018_1800_0000_0000;
      7'h3A:   w_glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
      7'h43:   w_glyph = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
      7'h48:   w_glyph = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
      7'h56:   w_glyph = 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000;
      default: w_glyph = '0;
    endcase
  end

  assign w_sel = {4'(4'd15 - i_line), 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pixel <= '0;
    else        r_pixel <= w_glyph[w_sel +: 8];
  end

  assign o_pixel = r_pixel;

endmodule

// File: rtl/voltage_text_buffer.sv
// Per-channel voltage text store: INIT fills default rows, updates are BCD-converted and
// written as "CHnn: d.dddV"; the draw stage reads glyph pixels with 2-clock latency.
module voltage_text_buffer #(
  parameter int unsigned ROWS = voltage_text_buffer_pkg::ROWS,
  parameter int unsigned COLS = voltage_text_buffer_pkg::COLS
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [voltage_text_buffer_pkg::XY_W-1:0]   text_xy,
  input  logic [voltage_text_buffer_pkg::LINE_W-1:0] text_line,
  output logic [voltage_text_buffer_pkg::PIX_W-1:0]  char_pixel,
  input  logic                                     upd_valid,
  output logic                                     upd_ready,
  input  logic [voltage_text_buffer_pkg::CH_W-1:0]   upd_ch,
  input  logic [voltage_text_buffer_pkg::MV_W-1:0]   upd_mv
);
  import voltage_text_buffer_pkg::*;

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_col;
  upd_t               r_upd;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic               r_ready;
  logic [CODE_W-1:0]  r_code;
  logic [LINE_W-1:0]  r_line;
  // ASCII is 7-bit, so the store keeps only the bits the font lookup uses.
  logic [CODE_W-1:0]  r_mem [DEPTH];

  logic               w_accept;
  logic               w_cnt_last;
  logic               w_ch_ok;
  logic               w_we;
  logic [AW-1:0]      w_waddr;
  logic [CODE_W-1:0]  w_wdata;
  logic               w_ready_nxt;

  assign w_accept  = upd_valid && r_ready;
  assign w_ch_ok   = (32'(r_upd.ch) < ROWS);
  assign w_bcd_adj = dd_adjust(r_bcd);

  always_comb begin
    w_cnt_last = 1'b0;
    case (r_state)
      ST_INIT:    w_cnt_last = (r_cnt == CNT_W'(DEPTH - 1));
      ST_CONVERT: w_cnt_last = (r_cnt == CNT_W'(CONV_CYCLES - 1));
      ST_WRITE:   w_cnt_last = (r_cnt == CNT_W'(COLS - 1));
      default:    w_cnt_last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_INIT;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:    if (w_cnt_last) w_state_nxt = ST_IDLE;
      ST_IDLE:    if (w_accept)   w_state_nxt = ST_CONVERT;
      ST_CONVERT: if (w_cnt_last) w_state_nxt = ST_WRITE;
      ST_WRITE:   if (w_cnt_last) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_INIT;
    endcase
  end

  // Output decode: store write port and next ready value
  always_comb begin
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = AW'(r_cnt);
        w_wdata = CODE_W'(text_char(r_col, r_row + 8'd1, '0));
      end
      ST_WRITE: begin
        w_we    = w_ch_ok;
        w_waddr = AW'(32'(r_upd.ch) * COLS + 32'(r_cnt));
        w_wdata = CODE_W'(text_char(r_cnt, 8'(r_upd.ch) + 8'd1, r_bcd));
      end
      default: ;
    endcase
  end

  // Sequencing counters, captured update and BCD conversion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_upd   <= '0;
      r_bcd   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      case (r_state)
        ST_INIT: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_row <= '0;
            r_col <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_col == CNT_W'(COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_upd <= '{ch: upd_ch, mv: upd_mv};
            r_bcd <= '0;
          end
        end
        ST_CONVERT: begin
          r_bcd    <= {w_bcd_adj[BCD_W-2:0], r_upd.mv[MV_W-1]};
          r_upd.mv <= {r_upd.mv[MV_W-2:0], 1'b0};
          r_cnt    <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        ST_WRITE: r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        default:  r_cnt <= '0;
      endcase
    end
  end

  // Character store: no reset, read-before-write on address collision
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code <= '0;
      r_line <= '0;
    end else begin
      r_code <= (32'(text_xy) < DEPTH) ? r_mem[AW'(text_xy)] : CODE_W'(ASCII_SPACE);
      r_line <= text_line;
    end
  end

  font_rom u_font_rom (
    .clk     (clk),
    .rst_n   (rst),
    .i_char  (r_code),
    .i_line  (r_line),
    .o_pixel (char_pixel)
  );

  assign upd_ready = r_ready;

endmodule

// File: tb/tb_voltage_text_buffer.sv
// Directed bench for voltage_text_buffer: reads are scored through an expected-pixel queue
// against a text model of the store and a reference copy of the glyphs.
module tb_voltage_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  text_xy;
  logic [3:0]  text_line;
  logic [7:0]  char_pixel;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_ch;
  logic [11:0] upd_mv;

  voltage_text_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .text_xy    (text_xy),
    .text_line  (text_line),
    .char_pixel (char_pixel),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_ch     (upd_ch),
    .upd_mv     (upd_mv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] model [156];

  typedef struct {
    int         due;
    logic [7:0] exp;
    int         xy;
    int         line;
  } sb_t;
  sb_t q[$];

  function automatic logic [127:0] glyph(input logic [7:0] c);
    case (c)
      8'h30:   return 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      8'h31:   return 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      8'h32:   return 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      8'h33:   return 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      8'h34:   return 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      8'h35:   return 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      8'h36:   return 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      8'h37:   return 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      8'h38:   return 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      8'h39:   return 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      8'h2E:   return 128'h0000_0000_0000_0000_0018_1800_0000_0000;
      8'h3A:   return 128'h0000_0000_1818_0000_0018_1800_0000_0000;
      8'h43:   return 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
      8'h48:   return 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
      8'h56:   return 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000;
      default: return '0;
    endcase
  endfunction

  function automatic logic [7:0] exp_pixel(input int xy, input int line);
    logic [7:0]   c;
    logic [127:0] s;
    c = (xy >= 156) ? 8'h20 : model[xy];
    s = glyph(c) >> (8 * (15 - line));
    return s[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; then score any read whose pixel is due now.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check($sformatf("pix xy=%0d ln=%0d", e.xy, e.line), 32'(char_pixel), 32'(e.exp));
    end
  endtask

  task automatic drive_read(input int xy, input int line);
    sb_t e;
    text_xy   = 8'(xy);
    text_line = 4'(line);
    e.due  = cyc + 2;
    e.exp  = exp_pixel(xy, line);
    e.xy   = xy;
    e.line = line;
    q.push_back(e);
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      for (int l = 0; l < 16; l++) begin
        drive_read(a, l);
        tick();
      end
    end
    tick();
    tick();
  endtask

  task automatic set_row_model(input int row, input int mv);
    string s;
    s = $sformatf("CH%02d: %0d.%03dV", row + 1, mv / 1000, mv % 1000);
    for (int c = 0; c < 12; c++) model[row * 12 + c] = s[c];
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (upd_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (upd_ready !== 1'b1) check({tag, "_timeout"}, 32'(upd_ready), 32'd1);
  endtask

  // Offer one update and return the edge count at which it was accepted.
  task automatic offer(input int ch, input int mv, output int acc);
    int n;
    upd_ch    = 4'(ch);
    upd_mv    = 12'(mv);
    upd_valid = 1'b1;
    wait_ready("offer", n);
    tick();
    acc = cyc;
  endtask

  task automatic release_and_init(input string tag);
    int n;
    rst = 1'b1;
    wait_ready(tag, n);
    check(tag, 32'(n), 32'd156);
    for (int r = 0; r < 13; r++) set_row_model(r, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int n;

    rst       = 1'b0;
    upd_valid = 1'b0;
    upd_ch    = '0;
    upd_mv    = '0;
    text_xy   = '0;
    text_line = 4'd5;
    repeat (3) tick();
    check("rst_ready", 32'(upd_ready), 32'd0);
    check("rst_pixel", 32'(char_pixel), 32'd0);

    // Default text after INIT; 'C' line 5 at address 0.
    release_and_init("init_len");
    drive_read(0, 5);
    tick();
    tick();
    check("C_line5", 32'(char_pixel), 32'h0000_00C0);
    read_range(0, 155);

    // ch=2, 3299 mV, with a read colliding with the column-6 write.
    offer(2, 3299, acc);
    upd_valid = 1'b0;
    check("ready_drop", 32'(upd_ready), 32'd0);
    while (cyc < acc + 18) tick();
    drive_read(30, 5);
    tick();
    model[30] = "3";
    drive_read(30, 5);
    tick();
    tick();
    tick();
    wait_ready("ch2", n);
    check("ready_edge_ch2", 32'(cyc + 1 - acc), 32'd25);
    set_row_model(2, 3299);
    read_range(23, 36);

    // Back-to-back updates with valid held high.
    offer(12, 4095, acc);
    upd_ch = 4'd0;
    upd_mv = 12'd0;
    wait_ready("b2b", n);
    tick();
    acc2      = cyc;
    upd_valid = 1'b0;
    check("b2b_gap", 32'(acc2 - acc), 32'd25);
    wait_ready("b2b_done", n);
    set_row_model(12, 4095);
    set_row_model(0, 0);
    read_range(144, 155);
    read_range(0, 11);

    // Out-of-range channel: same timing, no store change.
    offer(14, 1234, acc);
    upd_valid = 1'b0;
    wait_ready("ch14", n);
    check("ready_edge_ch14", 32'(cyc + 1 - acc), 32'd25);
    read_range(0, 155);

    // Reset five clocks into WRITE of ch=1.
    offer(1, 1234, acc);
    upd_valid = 1'b0;
    while (cyc < acc + 17) tick();
    rst = 1'b0;
    #1;
    check("midwr_ready", 32'(upd_ready), 32'd0);
    check("midwr_pixel", 32'(char_pixel), 32'd0);
    tick();
    tick();
    release_and_init("reinit_len");
    read_range(12, 35);

    // Addresses at and beyond the end of the store read as blank.
    read_range(154, 157);
    read_range(200, 200);
    check("xy200_pixel", 32'(char_pixel), 32'd0);
    read_range(255, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
